// File: rtl/core_ex_hazard_ctrl.sv
// EX-stage hazard/issue control: operand forwarding selects, load-use issue gating and a load queue; CORE_EX_FWD_EN enables forwarding.
// Zero latency (outputs combinational from state and inputs); stalls EX only when a load cannot enter a full queue.
module core_ex_hazard_ctrl #(
  parameter int MAX_LOADS = 2
) (
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic       issue_valid_i,
  output logic       issue_ready_o,
  input  logic [4:0] rs1_addr_i,
  input  logic [4:0] rs2_addr_i,
  input  logic       rs1_used_i,
  input  logic       rs2_used_i,
  input  logic [4:0] rd_addr_i,
  input  logic       rd_we_i,
  input  logic       is_load_i,
  input  logic       flush_i,
  input  logic       load_resp_valid_i,
  output logic       ex_stall_o,
  output logic [1:0] fwd_a_sel_o,
  output logic [1:0] fwd_b_sel_o,
  output logic [4:0] load_rd_o,
  output logic       resp_err_o
);

  localparam int PW = (MAX_LOADS > 1) ? $clog2(MAX_LOADS) : 1;
  localparam int CW = $clog2(MAX_LOADS + 1);

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       we;
    logic       load;
  } ex_ent_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_EX = 2'b01,
    FWD_LD = 2'b10
  } fwd_sel_e;

  ex_ent_t                      ex_q;
  logic [4:0]                   q_rd [MAX_LOADS];
  logic [PW-1:0]                head_q;
  logic [PW-1:0]                tail_q;
  logic [CW-1:0]                cnt_q;
  logic                         err_q;

  logic [MAX_LOADS-1:0][4:0]    q_ord;
  logic [3:0]                   cls_a;
  logic [3:0]                   cls_b;
  logic                         stall_a;
  logic                         stall_b;
  logic                         push;
  logic                         pop;

  function automatic logic [PW-1:0] slot(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= MAX_LOADS) s = s - MAX_LOADS;
    return PW'(s);
  endfunction

  // Hit class of one source: [0] EX non-load, [1] EX load, [2] youngest queue hit is the
  // head with data returning now, [3] any other queue hit. EX (newest) wins over the queue.
  function automatic logic [3:0] classify(
    input logic [4:0]                rs,
    input logic                      used,
    input ex_ent_t                   ex,
    input logic [MAX_LOADS-1:0][4:0] ord,
    input logic [CW-1:0]             cnt,
    input logic                      resp
  );
    logic       ex_hit;
    logic       q_hit;
    logic       q_head;
    logic [3:0] cls;
    cls    = 4'b0000;
    q_hit  = 1'b0;
    q_head = 1'b0;
    ex_hit = ex.vld && ex.we && (ex.rd == rs);
    for (int k = 0; k < MAX_LOADS; k++) begin
      if ((CW'(k) < cnt) && (ord[k] == rs)) begin
        q_hit  = 1'b1;
        q_head = (k == 0);
      end
    end
    if (used && (rs != 5'd0)) begin
      if (ex_hit) begin
        cls[0] = !ex.load;
        cls[1] = ex.load;
      end else if (q_hit) begin
        cls[2] = q_head && resp;
        cls[3] = !(q_head && resp);
      end
    end
    return cls;
  endfunction

  always_comb begin
    for (int k = 0; k < MAX_LOADS; k++) begin
      q_ord[k] = q_rd[slot(head_q, k)];
    end
  end

  assign cls_a = classify(rs1_addr_i, rs1_used_i, ex_q, q_ord, cnt_q, load_resp_valid_i);
  assign cls_b = classify(rs2_addr_i, rs2_used_i, ex_q, q_ord, cnt_q, load_resp_valid_i);

`ifdef CORE_EX_FWD_EN
  assign stall_a = cls_a[1] | cls_a[3];
  assign stall_b = cls_b[1] | cls_b[3];
`else
  assign stall_a = |cls_a;
  assign stall_b = |cls_b;
`endif

  // A full queue only blocks the EX load when no response frees a slot this cycle.
  assign ex_stall_o    = ex_q.vld && ex_q.load && (cnt_q == CW'(MAX_LOADS)) && !load_resp_valid_i;
  assign issue_ready_o = !ex_stall_o && !flush_i && !stall_a && !stall_b;

  always_comb begin
    fwd_a_sel_o = FWD_RF;
    fwd_b_sel_o = FWD_RF;
`ifdef CORE_EX_FWD_EN
    if (issue_ready_o) begin
      if (cls_a[0])      fwd_a_sel_o = FWD_EX;
      else if (cls_a[2]) fwd_a_sel_o = FWD_LD;
      if (cls_b[0])      fwd_b_sel_o = FWD_EX;
      else if (cls_b[2]) fwd_b_sel_o = FWD_LD;
    end
`endif
  end

  assign push       = ex_q.vld && ex_q.load && !ex_stall_o && !flush_i;
  assign pop        = load_resp_valid_i && (cnt_q != '0);
  assign load_rd_o  = (cnt_q != '0) ? q_rd[head_q] : 5'd0;
  assign resp_err_o = err_q;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      ex_q <= '0;
    end else if (flush_i) begin
      ex_q <= '0;
    end else if (!ex_stall_o) begin
      if (issue_valid_i && issue_ready_o) begin
        ex_q <= '{vld: 1'b1, rd: rd_addr_i, we: rd_we_i, load: is_load_i};
      end else begin
        ex_q <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int k = 0; k < MAX_LOADS; k++) q_rd[k] <= 5'd0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        q_rd[tail_q] <= ex_q.rd;
        tail_q       <= slot(tail_q, 1);
      end
      if (pop) head_q <= slot(head_q, 1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
      if (load_resp_valid_i && (cnt_q == '0)) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_ex_hazard_ctrl.sv
// Scenario bench for core_ex_hazard_ctrl; expectations follow the CORE_EX_FWD_EN build setting.
module tb_core_ex_hazard_ctrl;

`ifdef CORE_EX_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef struct packed {
    logic       vld;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       fl;
    logic       resp;
  } stim_t;

  typedef struct packed {
    logic       rdy;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       stall;
    logic [4:0] lrd;
    logic       err;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       arst_ni = 1'b0;
  logic       issue_valid, issue_ready;
  logic [4:0] rs1_addr, rs2_addr, rd_addr;
  logic       rs1_used, rs2_used, rd_we, is_load, flush, load_resp_valid;
  logic       ex_stall, resp_err;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [4:0] load_rd;

  int   n_run = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk_i = ~clk_i;

  core_ex_hazard_ctrl #(.MAX_LOADS(2)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
    .rd_addr_i(rd_addr), .rd_we_i(rd_we), .is_load_i(is_load),
    .flush_i(flush), .load_resp_valid_i(load_resp_valid),
    .ex_stall_o(ex_stall), .fwd_a_sel_o(fwd_a_sel), .fwd_b_sel_o(fwd_b_sel),
    .load_rd_o(load_rd), .resp_err_o(resp_err)
  );

  function automatic stim_t mk(input int vld, input int rs1, input int u1, input int rs2,
                               input int u2, input int rd, input int we, input int ld);
    stim_t s;
    s.vld = 1'(vld); s.rs1 = 5'(rs1); s.u1 = 1'(u1);
    s.rs2 = 5'(rs2); s.u2 = 1'(u2);
    s.rd = 5'(rd); s.we = 1'(we); s.ld = 1'(ld);
    s.fl = 1'b0; s.resp = 1'b0;
    return s;
  endfunction

  function automatic stim_t nop();        return mk(0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic stim_t alu(int rd);  return mk(1, 0, 0, 0, 0, rd, 1, 0); endfunction
  function automatic stim_t ldi(int rd);  return mk(1, 0, 0, 0, 0, rd, 1, 1); endfunction
  function automatic stim_t rsp(stim_t s); stim_t t; t = s; t.resp = 1'b1; return t; endfunction
  function automatic stim_t fls(stim_t s); stim_t t; t = s; t.fl = 1'b1; return t; endfunction

  function automatic exp_t xp(int rdy, int fa, int fb, int st, int lrd, int err);
    exp_t e;
    e.rdy = 1'(rdy); e.fa = 2'(fa); e.fb = 2'(fb);
    e.stall = 1'(st); e.lrd = 5'(lrd); e.err = 1'(err);
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t e;
    e.rdy = issue_ready; e.fa = fwd_a_sel; e.fb = fwd_b_sel;
    e.stall = ex_stall; e.lrd = load_rd; e.err = resp_err;
    return e;
  endfunction

  function automatic string fmt(exp_t e);
    return $sformatf("rdy=%b fa=%b fb=%b stall=%b lrd=%0d err=%b", e.rdy, e.fa, e.fb, e.stall, e.lrd, e.err);
  endfunction

  task automatic apply(input stim_t s);
    @(negedge clk_i);
    issue_valid = s.vld; rs1_addr = s.rs1; rs1_used = s.u1;
    rs2_addr = s.rs2; rs2_used = s.u2; rd_addr = s.rd; rd_we = s.we;
    is_load = s.ld; flush = s.fl; load_resp_valid = s.resp;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    arst_ni = 1'b0;
    issue_valid = 0; rs1_used = 0; rs2_used = 0; flush = 0; load_resp_valid = 0;
    @(negedge clk_i);
    arst_ni = 1'b1;
  endtask

  task automatic test_reset();
    stim_t st[2];
    exp_t  ex[2];
    exp_t  got, want;
    arst_ni = 1'b0;
    st[0] = nop();                       ex[0] = xp(1, 0, 0, 0, 0, 0);
    st[1] = mk(1, 5, 1, 5, 1, 5, 1, 1);  ex[1] = xp(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      apply(st[i]); sb.push_back(ex[i]); #1;
      got = observe(); want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
    arst_ni = 1'b1;
  endtask

  task automatic test_alu_fwd();
    stim_t st[10];
    exp_t  ex[10];
    exp_t  got, want;
    do_reset();
    st[0] = alu(5);                       ex[0] = xp(1, 0, 0, 0, 0, 0);
    st[1] = mk(1, 5, 1, 0, 0, 6, 1, 0);   ex[1] = FWD_EN ? xp(1, 1, 0, 0, 0, 0) : xp(0, 0, 0, 0, 0, 0);
    st[2] = st[1];                        ex[2] = xp(1, 0, 0, 0, 0, 0);
    st[3] = mk(1, 0, 0, 6, 1, 0, 0, 0);   ex[3] = FWD_EN ? xp(1, 0, 1, 0, 0, 0) : xp(0, 0, 0, 0, 0, 0);
    st[4] = mk(1, 6, 1, 6, 1, 0, 0, 0);   ex[4] = xp(1, 0, 0, 0, 0, 0);
    st[5] = alu(0);                       ex[5] = xp(1, 0, 0, 0, 0, 0);
    st[6] = mk(1, 0, 1, 0, 1, 8, 0, 0);   ex[6] = xp(1, 0, 0, 0, 0, 0);
    st[7] = mk(1, 8, 1, 0, 0, 0, 0, 0);   ex[7] = xp(1, 0, 0, 0, 0, 0);
    st[8] = alu(9);                       ex[8] = xp(1, 0, 0, 0, 0, 0);
    st[9] = mk(1, 9, 0, 9, 0, 0, 0, 0);   ex[9] = xp(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      apply(st[i]); sb.push_back(ex[i]); #1;
      got = observe(); want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL alu_fwd[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_load_use();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  got, want;
    do_reset();
    st[0] = ldi(7);                       ex[0] = xp(1, 0, 0, 0, 0, 0);
    st[1] = mk(1, 0, 0, 7, 1, 9, 1, 0);   ex[1] = xp(0, 0, 0, 0, 0, 0);
    st[2] = st[1];                        ex[2] = xp(0, 0, 0, 0, 7, 0);
    st[3] = rsp(st[1]);                   ex[3] = FWD_EN ? xp(1, 0, 2, 0, 7, 0) : xp(0, 0, 0, 0, 7, 0);
    st[4] = st[1];                        ex[4] = xp(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(st[i]); sb.push_back(ex[i]); #1;
      got = observe(); want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL load_use[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_queue_full();
    stim_t st[10];
    exp_t  ex[10];
    exp_t  got, want;
    do_reset();
    st[0] = ldi(10);                           ex[0] = xp(1, 0, 0, 0, 0, 0);
    st[1] = ldi(11);                           ex[1] = xp(1, 0, 0, 0, 0, 0);
    st[2] = ldi(12);                           ex[2] = xp(1, 0, 0, 0, 10, 0);
    st[3] = alu(13);                           ex[3] = xp(0, 0, 0, 1, 10, 0);
    st[4] = rsp(alu(13));                      ex[4] = xp(1, 0, 0, 0, 10, 0);
    st[5] = mk(1, 12, 1, 0, 0, 0, 0, 0);       ex[5] = xp(0, 0, 0, 0, 11, 0);
    st[6] = rsp(mk(1, 11, 1, 0, 0, 0, 0, 0));  ex[6] = FWD_EN ? xp(1, 2, 0, 0, 11, 0) : xp(0, 0, 0, 0, 11, 0);
    st[7] = rsp(nop());                        ex[7] = xp(1, 0, 0, 0, 12, 0);
    st[8] = rsp(nop());                        ex[8] = xp(1, 0, 0, 0, 0, 0);
    st[9] = nop();                             ex[9] = xp(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      apply(st[i]); sb.push_back(ex[i]); #1;
      got = observe(); want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL queue_full[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_youngest();
    stim_t st[6];
    exp_t  ex[6];
    exp_t  got, want;
    do_reset();
    st[0] = ldi(20);                           ex[0] = xp(1, 0, 0, 0, 0, 0);
    st[1] = ldi(20);                           ex[1] = xp(1, 0, 0, 0, 0, 0);
    st[2] = nop();                             ex[2] = xp(1, 0, 0, 0, 20, 0);
    st[3] = rsp(mk(1, 20, 1, 0, 0, 0, 0, 0));  ex[3] = xp(0, 0, 0, 0, 20, 0);
    st[4] = st[3];                             ex[4] = FWD_EN ? xp(1, 2, 0, 0, 20, 0) : xp(0, 0, 0, 0, 20, 0);
    st[5] = nop();                             ex[5] = xp(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      apply(st[i]); sb.push_back(ex[i]); #1;
      got = observe(); want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL youngest[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_flush();
    stim_t st[8];
    exp_t  ex[8];
    exp_t  got, want;
    do_reset();
    st[0] = ldi(7);         ex[0] = xp(1, 0, 0, 0, 0, 0);
    st[1] = fls(alu(4));    ex[1] = xp(0, 0, 0, 0, 0, 0);
    st[2] = nop();          ex[2] = xp(1, 0, 0, 0, 0, 0);
    st[3] = rsp(nop());     ex[3] = xp(1, 0, 0, 0, 0, 0);
    st[4] = nop();          ex[4] = xp(1, 0, 0, 0, 0, 1);
    st[5] = ldi(3);         ex[5] = xp(1, 0, 0, 0, 0, 1);
    st[6] = nop();          ex[6] = xp(1, 0, 0, 0, 0, 1);
    st[7] = nop();          ex[7] = xp(1, 0, 0, 0, 3, 1);
    for (int i = 0; i < 8; i++) begin
      apply(st[i]); sb.push_back(ex[i]); #1;
      got = observe(); want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL flush[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t st[6];
    exp_t  ex[6];
    exp_t  got, want;
    do_reset();
    st[0] = ldi(9);         ex[0] = xp(1, 0, 0, 0, 0, 0);
    st[1] = nop();          ex[1] = xp(1, 0, 0, 0, 0, 0);
    st[2] = nop();          ex[2] = xp(1, 0, 0, 0, 9, 0);
    st[3] = nop();          ex[3] = xp(1, 0, 0, 0, 0, 0);
    st[4] = rsp(nop());     ex[4] = xp(1, 0, 0, 0, 0, 0);
    st[5] = nop();          ex[5] = xp(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) do_reset();
      apply(st[i]); sb.push_back(ex[i]); #1;
      got = observe(); want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset_mid[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  initial begin
    issue_valid = 0; rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
    rd_addr = 0; rd_we = 0; is_load = 0; flush = 0; load_resp_valid = 0;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_queue_full();
    test_youngest();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/core_ex_hazard_ctrl.md
# core_ex_hazard_ctrl

Hazard and issue controller for the execution stage. It tracks the destination register of the instruction held in the EX result register and a small in-order queue of outstanding loads. From that state it drives operand-forwarding selects, gates instruction issue from decode, and stalls the EX register when the load queue cannot accept a load. It sits between decode, the execution stage and the load-response path of the data memory interface.

## Interface
- MAX_LOADS, 2, depth of the outstanding-load queue (1..4).
- clk_i  in  1  clock.
- arst_ni  in  1  reset, asynchronous, active-low.
- issue_valid_i  in  1  decode presents an instruction.
- issue_ready_o  out  1  instruction accepted this cycle when high together with issue_valid_i.
- rs1_addr_i, rs2_addr_i  in  5  source register addresses.
- rs1_used_i, rs2_used_i  in  1  source actually read by the instruction.
- rd_addr_i  in  5  destination register.
- rd_we_i  in  1  instruction writes rd.
- is_load_i  in  1  instruction is a load.
- flush_i  in  1  kill the decode and EX instructions (branch redirect).
- load_resp_valid_i  in  1  in-order load data returns this cycle.
- ex_stall_o  out  1  hold the EX register (drives the execution stage stall input).
- fwd_a_sel_o, fwd_b_sel_o  out  2  operand source: 00 register file, 01 EX result, 10 load response data.
- load_rd_o  out  5  rd of the queue head, used as the register-file write address for load data.
- resp_err_o  out  1  sticky flag: a response arrived while the queue was empty.

## Operation
- **EX entry.** Holds {valid, rd, we, load}.
  - Captures the accepted instruction.
  - Otherwise becomes a bubble, unless ex_stall_o holds it.
  - rd==0 or we==0 is treated as invalid for hazard matching.
- **Load queue.** Circular FIFO of rd addresses.
  - Count range is 0..MAX_LOADS; pointers wrap modulo MAX_LOADS.
  - Push: an EX entry with load=1 leaves EX, i.e. when ex_stall_o is low.
  - Pop: load_resp_valid_i with count>0.
- **Source match**, per used source rsN ≠ 0, in priority order (newest first):
  - EX entry matches and is not a load: fwd=01, no stall.
  - EX entry matches and is a load: load-use hazard, so stall issue.
  - Otherwise, the youngest matching queue entry decides:
    - If it is the head and load_resp_valid_i is high: fwd=10.
    - Otherwise: stall issue.
  - No match: fwd=00.
- **ex_stall_o** = EX entry is a load && count==MAX_LOADS && !load_resp_valid_i. A simultaneous push and pop at full is allowed.
- **issue_ready_o** = !ex_stall_o && !flush_i && no source stall.
  - When issue_valid_i is low, source stalls are still evaluated; this only affects fwd outputs.
  - fwd outputs are 00 whenever issue_ready_o is low.
- **flush_i.**
  - EX entry becomes a bubble next edge, overriding ex_stall_o. A flushed load is never pushed.
  - Queued loads are not affected.
- **resp_err_o.**
  - Set on load_resp_valid_i with count==0; the queue is unchanged.
  - Cleared only by reset.

## Timing
- Reset values:
  - EX entry invalid, count 0, pointers 0, resp_err_o 0.
  - ex_stall_o 0, fwd selects 00, load_rd_o 0.
  - issue_ready_o equals the reset-state combinational value, i.e. 1.
- Outputs are combinational from registered state and current inputs. There is no added latency.
- An accepted instruction is in EX one cycle later. Its rd is matchable by the next issue.
- A load leaves EX into the queue at the edge after its EX cycle, unless stalled.
- A response pops the head at the edge. Dependents issue in the same response cycle via fwd=10.
- Back-to-back: load followed by a dependent instruction gives at least 1 bubble, then issue at the response cycle.
- Reset mid-operation clears all pending loads; late responses after reset set resp_err_o.

## Configuration
- CORE_EX_FWD_EN defined: forwarding as above.
- CORE_EX_FWD_EN undefined:
  - Any source matching the EX entry or any queue entry stalls issue.
  - fwd selects are constant 00.
  - Queue, stall and error logic are unchanged.

## Test plan
- After reset: issue rd=5 ALU, then an instruction with rs1=5 -> second issue accepted in the next cycle with fwd_a_sel_o=01, issue_ready_o=1.
- Issue load rd=7, then rs2=7 -> issue_ready_o=0 until load_resp_valid_i. In that cycle fwd_b_sel_o=10, load_rd_o=7, and the instruction is accepted.
- MAX_LOADS=2, three back-to-back loads with no responses -> third load held with ex_stall_o=1. A response arriving then lets it push in the same cycle (count stays 2).
- rs1=0 with an EX entry rd=0 we=1 -> fwd_a_sel_o=00, no stall.
- Load in EX plus flush_i -> EX becomes a bubble, count unchanged. A later response with count==0 sets resp_err_o=1, held until reset.
- Build without CORE_EX_FWD_EN: ALU rd=3 followed by rs1=3 -> one stall cycle, fwd_a_sel_o=00, then accepted.
